// File: rtl/intan_spi_sequencer_pkg.sv
// Shared definitions for the Intan SPI command sequencer: state encoding,
// control-register byte map and command width.
package intan_spi_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    localparam int BYTE_CTRL      = 0;
    localparam int BYTE_NUM_CMDS  = 1;
    localparam int BYTE_CMD_BASE  = 4;

    localparam int BIT_ENABLE     = 0;
    localparam int BIT_CONTINUOUS = 1;

    localparam int CMD_W          = 16;

endpackage

// File: rtl/intan_spi_shifter.sv
// SCLK divider and 16-bit MSB-first shift/sample engine. A start pulse while
// idle launches one word; done is high in the last cycle of the word.
module intan_spi_shifter
    import intan_spi_sequencer_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic             pl_clk,
    input  logic             pl_rstn,
    input  logic             start,
    input  logic [CMD_W-1:0] cmd,
    input  logic             miso,
    output logic             sclk,
    output logic             mosi,
    output logic             done,
    output logic [CMD_W-1:0] rx_word
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active_q, active_d;
    logic             phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic [CMD_W-1:0] shreg_q, shreg_d;
    logic [CMD_W-1:0] rx_q, rx_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        rx_d     = rx_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        done     = 1'b0;

        if (active_q) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            // MISO is captured during the first cycle SCLK is high.
            if (phase_q && (div_q == '0)) begin
                rx_d = {rx_q[CMD_W-2:0], miso};
            end
            if (div_q == DIV_LAST) begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                    if (bit_q == 4'(CMD_W - 1)) begin
                        active_d = 1'b0;
                        mosi_d   = 1'b0;
                        done     = 1'b1;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shreg_d = {shreg_q[CMD_W-2:0], 1'b0};
                        mosi_d  = shreg_q[CMD_W-2];
                    end
                end
            end
        end else if (start) begin
            active_d = 1'b1;
            phase_d  = 1'b0;
            div_d    = '0;
            bit_d    = 4'd0;
            shreg_d  = cmd;
            sclk_d   = 1'b0;
            mosi_d   = cmd[CMD_W-1];
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge pl_clk or negedge pl_rstn) begin
        if (!pl_rstn) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            div_q    <= '0;
            bit_q    <= 4'd0;
            shreg_q  <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            rx_q     <= rx_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign rx_word = rx_q;

endmodule

// File: rtl/intan_spi_sequencer.sv
// Walks a table of 16-bit Intan commands over SPI, one CS-framed word per
// entry, and reports each received word with its table index.
module intan_spi_sequencer
    import intan_spi_sequencer_pkg::*;
#(
    parameter int NUM_REGS       = 64,
    parameter int CLK_DIV        = 2,
    parameter int CS_HIGH_CYCLES = 4,
    parameter int MAX_CMDS       = 16
) (
    input  logic                  pl_clk,
    input  logic                  pl_rstn,
    input  logic [NUM_REGS*8-1:0] pl_control_regs,
    output logic                  spi_cs_n,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic [15:0]           rx_data,
    output logic                  rx_valid,
    output logic [3:0]            rx_index,
    output logic                  sweep_done,
    output logic                  busy
);

    localparam int CNT_MAX = (CLK_DIV > CS_HIGH_CYCLES) ? CLK_DIV : CS_HIGH_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_HIGH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_prev_q;
    logic             sweep_pulse;

    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             rx_valid_q, rx_valid_d;
    logic [15:0]      rx_data_q, rx_data_d;
    logic [3:0]       rx_index_q, rx_index_d;
    logic             sweep_done_q, sweep_done_d;

    logic             enable, continuous;
    logic [7:0]       num_raw, num_clamped;
    logic [CMD_W-1:0] cmd_tab [MAX_CMDS];
    logic             shift_done;
    logic [CMD_W-1:0] shift_rx;
    logic             unused_regs;

    assign enable      = pl_control_regs[BYTE_CTRL*8 + BIT_ENABLE];
    assign continuous  = pl_control_regs[BYTE_CTRL*8 + BIT_CONTINUOUS];
    assign num_raw     = pl_control_regs[BYTE_NUM_CMDS*8 +: 8];
    assign num_clamped = (num_raw > 8'(MAX_CMDS)) ? 8'(MAX_CMDS) : num_raw;
    assign unused_regs = ^pl_control_regs;

    for (genvar k = 0; k < MAX_CMDS; k++) begin : g_cmd
        assign cmd_tab[k] = pl_control_regs[(BYTE_CMD_BASE + 2*k)*8 +: CMD_W];
    end

    intan_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .pl_clk  (pl_clk),
        .pl_rstn (pl_rstn),
        .start   (state_q == ST_LOAD),
        .cmd     (cmd_tab[idx_q]),
        .miso    (spi_miso),
        .sclk    (spi_sclk),
        .mosi    (spi_mosi),
        .done    (shift_done),
        .rx_word (shift_rx)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        sweep_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Single-shot needs a fresh enable edge; continuous only needs enable.
                if (enable && (num_clamped != 8'd0) && (continuous || !en_prev_q)) begin
                    state_d = ST_LOAD;
                    num_d   = num_clamped;
                    idx_d   = 4'd0;
                end
            end
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (shift_done) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q != GAP_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else if ({4'd0, idx_q} < num_q - 8'd1) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_LOAD;
                end else begin
                    sweep_pulse = 1'b1;
                    if (continuous && (num_clamped != 8'd0)) begin
                        idx_d   = 4'd0;
                        num_d   = num_clamped;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output flops are loaded from the next state so pins line up with state_q.
    always_comb begin
        cs_n_d       = !((state_d == ST_SHIFT) || (state_d == ST_HOLD));
        busy_d       = (state_d != ST_IDLE);
        rx_valid_d   = (state_q == ST_HOLD) && (state_d == ST_GAP);
        rx_data_d    = rx_valid_d ? shift_rx : rx_data_q;
        rx_index_d   = rx_valid_d ? idx_q : rx_index_q;
        sweep_done_d = sweep_pulse;
    end

    always_ff @(posedge pl_clk or negedge pl_rstn) begin
        if (!pl_rstn) begin
            state_q      <= ST_IDLE;
            idx_q        <= 4'd0;
            num_q        <= 8'd0;
            cnt_q        <= '0;
            en_prev_q    <= 1'b0;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 16'd0;
            rx_index_q   <= 4'd0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            num_q        <= num_d;
            cnt_q        <= cnt_d;
            en_prev_q    <= enable;
            cs_n_q       <= cs_n_d;
            busy_q       <= busy_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            rx_index_q   <= rx_index_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign spi_cs_n   = cs_n_q;
    assign busy       = busy_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign rx_index   = rx_index_q;
    assign sweep_done = sweep_done_q;

endmodule
